// File: rtl/dkong_video_pkg.sv
// Shared video types and timing constants for the dkong video core and its scan doubler.
package dkong_video_pkg;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  localparam int unsigned H_TOTAL = 768;
  localparam logic [8:0]  V_FIRST = 9'h0F8;

  localparam int unsigned SD_ACTIVE_W   = 256;
  localparam int unsigned SD_LINE_TICKS = 384;
  localparam int unsigned SD_HS_START   = 288;
  localparam int unsigned SD_HS_LEN     = 46;
  localparam logic [8:0]  SD_VS_FIRST   = 9'h1F0;
  localparam logic [8:0]  SD_VS_LAST    = 9'h1F3;

  function automatic logic in_span9(input logic [8:0] v, input logic [8:0] lo, input logic [8:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/dkong_scandoubler_line_ram.sv
// Ping-pong line store: simple dual-port, single clock, registered read that holds when idle.
module line_ram
  import dkong_video_pkg::*;
#(
  parameter int unsigned AW    = 9,
  parameter int unsigned DEPTH = 2 ** AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  rgb332_t mem [DEPTH];

  // Read and write always target opposite banks, so no bypass path is needed.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dkong_scandoubler.sv
// Line doubler: captures each 15 kHz line and replays the previous one twice per input line.
module dkong_scandoubler
  import dkong_video_pkg::*;
#(
  parameter int unsigned ACTIVE_W   = SD_ACTIVE_W,
  parameter int unsigned LINE_TICKS = SD_LINE_TICKS,
  parameter int unsigned HS_START   = SD_HS_START,
  parameter int unsigned HS_LEN     = SD_HS_LEN,
  parameter logic [8:0]  VS_FIRST   = SD_VS_FIRST,
  parameter logic [8:0]  VS_LAST    = SD_VS_LAST
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] htiming,
  input  logic [8:0] vtiming,
  input  logic       pix_valid,
  input  logic [7:0] pix_rgb,
  output logic       out_valid,
  output logic [7:0] out_rgb,
  output logic       out_de,
  output logic       out_hsync,
  output logic       out_vsync,
  output logic       ovf
);

  localparam int unsigned AW  = $clog2(ACTIVE_W);
  localparam int unsigned AWP = AW + 1;
  localparam int unsigned HW  = $clog2(LINE_TICKS);

  localparam logic [AW:0]   WADDR_FULL = AWP'(ACTIVE_W);
  localparam logic [HW-1:0] H_ACTIVE   = HW'(ACTIVE_W);
  localparam logic [HW-1:0] H_LAST     = HW'(LINE_TICKS - 1);
  localparam logic [HW-1:0] HS_LO      = HW'(HS_START);
  localparam logic [HW-1:0] HS_HI      = HW'(HS_START + HS_LEN);

  logic [9:0]    h_prev;
  logic          tick;
  logic          ls;

  logic          wbank;
  logic          bank_w;
  logic [AW:0]   waddr;
  logic [AW:0]   addr_w;
  logic          primed;
  logic          primed_nxt;
  logic [HW-1:0] out_h;
  logic [HW-1:0] out_h_nxt;

  logic          ram_we;
  logic [AW:0]   ram_waddr;
  logic          ram_re;
  logic [AW:0]   ram_raddr;
  logic [7:0]    ram_rdata;

  logic          s1_valid;
  logic          s1_de;
  logic          s1_hs;
  logic          s1_vs;

  // Everything below is computed against the post-tick view (bank, address, out_h)
  // so a pixel arriving with the line start lands at address 0 of the new bank.
  always_comb begin
    tick       = (htiming != h_prev);
    ls         = tick && (htiming == '0);
    bank_w     = ls ? ~wbank : wbank;
    addr_w     = ls ? '0 : waddr;
    primed_nxt = primed | (ls && (waddr != '0));

    out_h_nxt = out_h;
    if (ls) begin
      out_h_nxt = '0;
    end else if (tick) begin
      out_h_nxt = (out_h == H_LAST) ? '0 : out_h + HW'(1);
    end

    ram_we    = pix_valid && (addr_w < WADDR_FULL);
    ram_waddr = {bank_w, addr_w[AW-1:0]};
    ram_re    = tick && (out_h_nxt < H_ACTIVE);
    ram_raddr = {~bank_w, out_h_nxt[AW-1:0]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_prev <= '0;
      wbank  <= 1'b0;
      waddr  <= '0;
      out_h  <= '0;
      primed <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      h_prev <= htiming;
      wbank  <= bank_w;
      waddr  <= ram_we ? addr_w + AWP'(1) : addr_w;
      out_h  <= out_h_nxt;
      primed <= primed_nxt;
      if (pix_valid && !ram_we) ovf <= 1'b1;
    end
  end

  line_ram #(
    .AW(AWP)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(pix_rgb),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  // Stage 1 runs alongside the RAM read; stage 2 aligns sync/de with the read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_de     <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      out_valid <= 1'b0;
      out_rgb   <= '0;
      out_de    <= 1'b0;
      out_hsync <= 1'b0;
      out_vsync <= 1'b0;
    end else begin
      s1_valid <= tick;
      if (tick) begin
        s1_de <= primed_nxt && (out_h_nxt < H_ACTIVE);
        s1_hs <= (out_h_nxt >= HS_LO) && (out_h_nxt < HS_HI);
        s1_vs <= in_span9(vtiming, VS_FIRST, VS_LAST);
      end
      out_valid <= s1_valid;
      out_rgb   <= s1_de ? ram_rdata : '0;
      out_de    <= s1_de;
      out_hsync <= s1_hs;
      out_vsync <= s1_vs;
    end
  end

endmodule
